// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sdram_arbiter
// Brief   : Two-master round-robin arbiter/sequencer for one SDRAM port.
//           Issues the command, waits for the handshake and aborts on timeout.
// Revision: 1.0
// ============================================================================
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_read,
  input  logic              m0_write,
  output logic              m0_busy,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic              m1_busy,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  output logic              sd_read,
  output logic              sd_write,
  input  logic              sd_busy,
  input  logic              sd_ready,
  input  logic [DATA_W-1:0] sd_rdata,
  output logic              tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter value seen during the TMO_CYC-th cycle of ISSUE+WAIT
  localparam logic [7:0] c_tmo_last = 8'(TMO_CYC - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_op_wr;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_tmo_err;

  logic w_req0;
  logic w_req1;
  logic w_grant1;
  logic w_cnt_hit;
  logic w_capture;
  logic w_timeout;

  assign w_req0    = m0_read | m0_write;
  assign w_req1    = m1_read | m1_write;
  // On a tie the master that was not granted last wins
  assign w_grant1  = w_req1 & (~w_req0 | ~r_last);
  assign w_cnt_hit = (r_cnt == c_tmo_last);

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (sd_ready) begin
          w_next    = S_DONE;
          w_capture = ~r_op_wr;
        end else if (w_cnt_hit) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end else if (sd_busy) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sd_ready) begin
          w_next    = S_DONE;
          w_capture = ~r_op_wr;
        end else if (w_cnt_hit) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_op_wr   <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= 8'd0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (w_req0 | w_req1)) begin
        r_owner <= w_grant1;
        r_op_wr <= w_grant1 ? m1_write : m0_write;
        r_addr  <= w_grant1 ? m1_addr  : m0_addr;
        r_wdata <= w_grant1 ? m1_wdata : m0_wdata;
        r_cnt   <= 8'd0;
      end
      if (r_state == S_ISSUE || r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
      if (w_capture) begin
        if (r_owner) r_rdata1 <= sd_rdata;
        else         r_rdata0 <= sd_rdata;
      end
      if (w_timeout) r_tmo_err <= 1'b1;
      if (r_state == S_DONE) r_last <= r_owner;
    end
  end

  assign sd_addr  = r_addr;
  assign sd_wdata = r_wdata;
  assign sd_read  = (r_state == S_ISSUE) & ~r_op_wr;
  assign sd_write = (r_state == S_ISSUE) &  r_op_wr;
  assign m0_ready = (r_state == S_DONE) & ~r_owner;
  assign m1_ready = (r_state == S_DONE) &  r_owner;
  assign m0_busy  = w_req0 & ~m0_ready;
  assign m1_busy  = w_req1 & ~m1_ready;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;
  assign tmo_err  = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_arbiter
// Brief   : Vector table + scoreboard bench for sdram_arbiter (TMO_CYC = 8).
// Revision: 1.0
// ============================================================================
module tb_sdram_arbiter;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_in = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, sd_addr;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, sd_wdata;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic          m0_busy, m0_ready, m1_busy, m1_ready;
  logic          sd_read, sd_write, tmo_err;
  logic          sd_busy = 1'b0, sd_ready = 1'b0;
  logic [DW-1:0] sd_rdata = '0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_in(rst_in),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_busy(m0_busy), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_busy(m1_busy), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_read(sd_read), .sd_write(sd_write),
    .sd_busy(sd_busy), .sd_ready(sd_ready), .sd_rdata(sd_rdata), .tmo_err(tmo_err)
  );

  typedef struct {
    logic          r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            busy_at;   // cycle (from first strobe) sd_busy is driven, -1 never
    int            ready_at;  // cycle sd_ready is driven, -1 never
    logic [DW-1:0] sd_data;
    bit            drop_early;
    int            strobes;   // expected strobe-high cycles per transfer
    bit            is_tmo;
  } vec_t;

  typedef struct {
    bit            m;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd0, rd1;
    int            strobes;
    bit            tmo;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            m_last = 1'b1;
  logic [DW-1:0] m_rd[2] = '{16'h0, 16'h0};
  bit            m_tmo = 1'b0;
  vec_t          vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r0, logic w0, logic r1, logic w1,
                              logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [DW-1:0] d0, logic [DW-1:0] d1,
                              int b, int r, logic [DW-1:0] sd,
                              bit drop, int stb, bit tmo);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.busy_at = b; v.ready_at = r; v.sd_data = sd;
    v.drop_early = drop; v.strobes = stb; v.is_tmo = tmo;
    return v;
  endfunction

  // Reference model: round-robin order, per-master read data, sticky error
  task automatic push_exp(input vec_t v);
    bit   q[2];
    bit   first;
    exp_t e;
    q[0] = v.r0 | v.w0;
    q[1] = v.r1 | v.w1;
    first = (q[0] && q[1]) ? !m_last : q[1];
    for (int i = 0; i < 2; i++) begin
      bit m;
      m = (i == 0) ? first : !first;
      if (q[m]) begin
        e.m     = m;
        e.wr    = m ? v.w1 : v.w0;
        e.addr  = m ? v.a1 : v.a0;
        e.wdata = m ? v.d1 : v.d0;
        if (v.is_tmo) m_tmo = 1'b1;
        else if (!e.wr) m_rd[m] = v.sd_data;
        e.rd0 = m_rd[0];
        e.rd1 = m_rd[1];
        e.tmo = m_tmo;
        e.strobes = v.strobes;
        m_last = m;
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   k;
    int   strobes;
    bit   active;
    push_exp(v);
    m0_read = v.r0; m0_write = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_read = v.r1; m1_write = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    active = 1'b0; k = 0; strobes = 0;
    for (int n = 0; n < 80 && sb.size() > 0; n++) begin
      @(posedge clk); #1;
      if (m0_ready || m1_ready) begin
        e = sb.pop_front();
        chk("ready_owner", {31'b0, m1_ready}, {31'b0, e.m});
        chk("ready_onehot", {31'b0, m0_ready & m1_ready}, 32'd0);
        chk("m0_rdata", m0_rdata, e.rd0);
        chk("m1_rdata", m1_rdata, e.rd1);
        chk("tmo_err", {31'b0, tmo_err}, {31'b0, e.tmo});
        chk("strobe_cycles", strobes, e.strobes);
        if (e.m) begin m1_read = 1'b0; m1_write = 1'b0; end
        else     begin m0_read = 1'b0; m0_write = 1'b0; end
        active = 1'b0; strobes = 0;
      end else if (sd_read || sd_write) begin
        if (!active) begin
          active = 1'b1; k = 0;
          chk("sd_write", {31'b0, sd_write}, {31'b0, sb[0].wr});
          chk("sd_addr", sd_addr, sb[0].addr);
          if (sb[0].wr) chk("sd_wdata", sd_wdata, sb[0].wdata);
          chk("m0_busy", {31'b0, m0_busy}, {31'b0, m0_read | m0_write});
          chk("m1_busy", {31'b0, m1_busy}, {31'b0, m1_read | m1_write});
        end
        strobes++;
        if (v.drop_early) begin
          m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        end
      end
      if (active) begin
        sd_busy  = (k == v.busy_at);
        sd_ready = (k == v.ready_at);
        sd_rdata = v.sd_data;
        k++;
      end else begin
        sd_busy  = 1'b0;
        sd_ready = 1'b0;
      end
    end
    if (sb.size() > 0) begin
      chk("completion_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    sd_busy = 1'b0; sd_ready = 1'b0;
    @(posedge clk); #1;
    chk("ready_width", {31'b0, m0_ready | m1_ready}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_strobes"}, {30'b0, sd_read, sd_write}, 32'd0);
    chk({tag, "_ready"}, {30'b0, m0_ready, m1_ready}, 32'd0);
    chk({tag, "_busy"}, {30'b0, m0_busy, m1_busy}, 32'd0);
    chk({tag, "_tmo_err"}, {31'b0, tmo_err}, 32'd0);
    chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 32'd0);
    chk({tag, "_sd_addr"}, sd_addr, 32'd0);
    chk({tag, "_sd_wdata"}, sd_wdata, 32'd0);
  endtask

  initial begin
    // tie after reset -> m0 first, then m1
    vecs[0]  = mk(0,1,0,1, 24'h000100, 24'h000200, 16'hA0A0, 16'hB1B1, 0, 2, 16'h0, 0, 1, 0);
    vecs[1]  = mk(1,0,0,0, 24'h000010, 24'h0,      16'h0,    16'h0,    0, 3, 16'hBEEF, 0, 1, 0);
    // repeat tie: m0 granted last, so m1 first
    vecs[2]  = mk(0,1,0,1, 24'h000500, 24'h000400, 16'h2222, 16'h1111, 0, 1, 16'h0, 0, 1, 0);
    vecs[3]  = mk(0,0,1,1, 24'h0,      24'h000600, 16'h0,    16'h1234, 0, 1, 16'h0, 0, 1, 0);
    vecs[4]  = mk(0,0,1,0, 24'h0,      24'h000700, 16'h0,    16'h0,   -1, 0, 16'h5A5A, 0, 1, 0);
    vecs[5]  = mk(1,0,0,0, 24'h000800, 24'h0,      16'h0,    16'h0,    0, 2, 16'h7E57, 1, 1, 0);
    // sd_ready on the timeout cycle wins
    vecs[6]  = mk(1,0,0,0, 24'h000900, 24'h0,      16'h0,    16'h0,    0, TMO-1, 16'hC0DE, 0, 1, 0);
    vecs[7]  = mk(1,0,0,0, 24'h000A00, 24'h0,      16'h0,    16'h0,   -1, -1, 16'hDEAD, 0, TMO, 1);
    vecs[8]  = mk(0,0,0,1, 24'h0,      24'hFFFFFF, 16'h0,    16'h9999, 0, 2, 16'h0, 0, 1, 0);
    vecs[9]  = mk(0,0,1,0, 24'h0,      24'h000B00, 16'h0,    16'h0,    0, -1, 16'hDEAD, 0, 1, 1);
    vecs[10] = mk(1,0,0,0, 24'h000C00, 24'h0,      16'h0,    16'h0,    0, 1, 16'hFFFF, 0, 1, 0);
    vecs[11] = mk(0,1,0,1, 24'h000D00, 24'h000E00, 16'h3333, 16'h4444, 0, 1, 16'h0, 0, 1, 0);

    rst_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_in = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset while in WAIT: transfer abandoned, late sd_ready ignored
    m0_addr = 24'h000ABC; m0_read = 1'b1;
    for (int n = 0; n < 10 && !sd_read; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_seq_strobe", {31'b0, sd_read}, 32'd1);
    sd_busy = 1'b1;
    @(posedge clk); #1;
    sd_busy = 1'b0;
    chk("rst_seq_wait", {31'b0, sd_read}, 32'd0);
    @(posedge clk); #1;
    rst_in = 1'b0; m0_read = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("midreset");
    rst_in = 1'b1; sd_ready = 1'b1; sd_rdata = 16'hFFFF;
    @(posedge clk); #1;
    sd_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("late_ready_ignored", {28'b0, m0_ready, m1_ready, sd_read, sd_write}, 32'd0);
      @(posedge clk); #1;
    end
    m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0; m_tmo = 1'b0;
    run_vec(vecs[11]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
